local_eject_buffer: RTL

Collects flits that the ejector has decoded as local-bound (row 3'b100, col 3'b100) from the north, south, east and west channels. Up to four flits can become local in one cycle, and this block takes as many as it can hold into a multi-write circular FIFO. It drains them one per cycle to the processing element over a valid/ready handshake. Flits it cannot take stay in their channel, and the router deflects them.

---
 rtl/router_pkg.sv | 26 ++
 rtl/eject_select.sv | 43 ++++
 rtl/local_eject_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, direction codes and the local
// node coordinates used by the ejector.
// Flit layout: {gbo, dir[2:0], adr[5:0]}.
package router_pkg;

    localparam int FLIT_W  = 10;
    localparam int GBO_BIT = 9;
    localparam int DIR_MSB = 8;
    localparam int DIR_LSB = 6;
    localparam int ADR_MSB = 5;

    localparam logic [2:0] EAST  = 3'b000;
    localparam logic [2:0] WEST  = 3'b001;
    localparam logic [2:0] NORTH = 3'b010;
    localparam logic [2:0] SOUTH = 3'b011;

    localparam logic [2:0] LOCAL_ROW = 3'b100;
    localparam logic [2:0] LOCAL_COL = 3'b100;

    // Channel indices inside the 4-wide vectors of the eject path.
    localparam int CH_N = 0;
    localparam int CH_S = 1;
    localparam int CH_E = 2;
    localparam int CH_W = 3;

endpackage

// File: rtl/eject_select.sv
// Combinational acceptance selector for the local eject buffer.
// Ranks the four channels (gbo=1 first, then gbo=0; N,S,E,W within a class)
// and accepts the first min(free, valid count) of them.
// Ports:
//   valid  [3:0]  channel has a local-bound flit (index N,S,E,W = 0..3)
//   gbo    [3:0]  gbo bit of each channel's flit
//   free          free FIFO slots at start of cycle
//   accept [3:0]  channel taken this cycle
//   offset        per-channel write slot offset from wr_ptr (0..3)
//   nacc          number of accepted flits
module eject_select #(
    parameter int CNT_W = 4
) (
    input  logic [3:0]       valid,
    input  logic [3:0]       gbo,
    input  logic [CNT_W-1:0] free,
    output logic [3:0]       accept,
    output logic [3:0][1:0]  offset,
    output logic [2:0]       nacc
);
    import router_pkg::*;

    int taken;

    always_comb begin
        accept = '0;
        offset = '0;
        taken  = 0;
        // Pass 0 serves gbo=1 flits, pass 1 serves gbo=0 flits; the running
        // count doubles as the slot offset of the next accepted flit.
        for (int pass = 0; pass < 2; pass++) begin
            for (int ch = CH_N; ch <= CH_W; ch++) begin
                if (valid[ch] && (gbo[ch] == (pass == 0)) && (taken < int'(free))) begin
                    accept[ch] = 1'b1;
                    offset[ch] = 2'(taken);
                    taken      = taken + 1;
                end
            end
        end
        nacc = 3'(taken);
    end

endmodule

// File: rtl/local_eject_buffer.sv
// Local eject buffer: multi-write circular FIFO collecting local-bound flits
// from the N/S/E/W channels and draining one per cycle to the PE.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   {n,s,e,w}valid/flit      local-bound flit offered on each channel
//   {n,s,e,w}accept          flit taken this cycle (combinational)
//   lvalid, lflit, lready    head flit handshake towards the PE
//   occupancy                registered entry count
//   drop_seen                sticky flag: some valid flit was refused
module local_eject_buffer #(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = router_pkg::FLIT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      nvalid,
    input  logic                      svalid,
    input  logic                      evalid,
    input  logic                      wvalid,
    input  logic [FLIT_W-1:0]         nflit,
    input  logic [FLIT_W-1:0]         sflit,
    input  logic [FLIT_W-1:0]         eflit,
    input  logic [FLIT_W-1:0]         wflit,
    output logic                      naccept,
    output logic                      saccept,
    output logic                      eaccept,
    output logic                      waccept,
    output logic                      lvalid,
    output logic [FLIT_W-1:0]         lflit,
    input  logic                      lready,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      drop_seen
);
    import router_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [3:0]        valid;
    logic [3:0]        gbo;
    logic [FLIT_W-1:0] flit [4];
    logic [CNT_W-1:0]  free;
    logic [3:0]        sel_accept;
    logic [3:0][1:0]   sel_offset;
    logic [2:0]        sel_nacc;
    logic [3:0]        accept;
    logic [2:0]        nacc;
    logic              pop;

    assign valid      = {wvalid, evalid, svalid, nvalid};
    assign flit[CH_N] = nflit;
    assign flit[CH_S] = sflit;
    assign flit[CH_E] = eflit;
    assign flit[CH_W] = wflit;
    assign gbo        = {wflit[GBO_BIT], eflit[GBO_BIT], sflit[GBO_BIT], nflit[GBO_BIT]};

    // Space is judged on the start-of-cycle count only, so lready never
    // reaches the accept outputs.
    assign free = CNT_W'(DEPTH) - occupancy;

    eject_select #(.CNT_W(CNT_W)) u_select (
        .valid  (valid),
        .gbo    (gbo),
        .free   (free),
        .accept (sel_accept),
        .offset (sel_offset),
        .nacc   (sel_nacc)
    );

    // Nothing is taken while in reset, which also blocks storage writes.
    assign accept  = rst ? 4'b0000 : sel_accept;
    assign nacc    = rst ? 3'd0    : sel_nacc;
    assign naccept = accept[CH_N];
    assign saccept = accept[CH_S];
    assign eaccept = accept[CH_E];
    assign waccept = accept[CH_W];

    assign lvalid = (occupancy != '0);
    assign lflit  = mem[rd_ptr];
    assign pop    = lvalid && lready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            drop_seen <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(nacc);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            occupancy <= occupancy + CNT_W'(nacc) - CNT_W'(pop);
            if ((valid & ~accept) != 4'b0000)
                drop_seen <= 1'b1;
        end
    end

    // Accepted flits land in distinct consecutive slots from wr_ptr.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (accept[ch])
                mem[wr_ptr + PTR_W'(sel_offset[ch])] <= flit[ch];
        end
    end

endmodule
